arith_sched: RTL and testbench
==============================

# arith_sched

Issue scheduler for the `arith` unit. Accepts operations from two decode requesters over valid/ready handshakes and arbitrates them round-robin into a small in-order FIFO. Issues one operation per cycle into `arith` (`en`, one-hot class, `tag3`, operands). A register scoreboard blocks RAW and WAW hazards, and operands being written back in the acceptance cycle are patched from `arith`'s `data_out`.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RW`, 3: register-id width; the scoreboard has 2^RW bits.

Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-low.

Requester ports (repeated for `req1_*`):
- `req0_valid` in 1: request valid.
- `req0_ready` out 1: request accepted this cycle.
- `req0_cls` in 6: one-hot class {ari,lgc,sft,bit,cmv,lea}.
- `req0_tag` in 3: op tag.
- `req0_use` in 2: [0] src1 used, [1] src2 used.
- `req0_src1`, `req0_src2`, `req0_dst` in RW: register ids.
- `req0_d1`, `req0_d2` in 16: register-file operand values.

Other inputs:
- `hold` in 1: inhibits issue.
- `flush` in 1: discards queued operations.
- `data_out` in 16: `arith` result, low half.
- `data_out_wr` in 1: `arith` write strobe.

Issue outputs:
- `en` out 1: issue strobe.
- `ari`, `lgc`, `sft`, `bit`, `cmv`, `lea` out 1 each: class one-hot.
- `tag3` out 3: op tag.
- `data_in1`, `data_in2` out 16: operands.
- `fwd_en1`, `fwd_en2` out 1: tied 0.

Writeback outputs:
- `wb_valid` out 1: an issued op's result is on `data_out` this cycle.
- `wb_dst` out RW: destination of that op.

## Operation
- **Execute tracker.** `ex_valid`/`ex_dst` are registered when `en`=1. `wb_valid` = `ex_valid`; `wb_dst` = `ex_dst`.
- **Clear.** When `wb_valid`=1, `clr`[`ex_dst`] is active this cycle. `busy[ex_dst]` clears at the cycle end, whether or not `data_out_wr` is set.
- **Hazard (per requester).** A request is blocked when:
  - a used source has `busy`=1 and is not the reg cleared this cycle, or
  - `busy[dst]`=1 and dst is not the reg cleared this cycle.
- **Eligibility.** eligible = valid & !blocked & !full & !flush.
- **Arbitration.**
  - One push per cycle.
  - If both requesters are eligible, pointer `rr` chooses; otherwise the single eligible one wins.
  - `rr` points to the loser after a contested grant.
  - `reqN_ready` = grant N.
- **Push.** The FIFO entry stores cls, tag, dst, and the operands.
  - A used source equal to `ex_dst` while `wb_valid` & `data_out_wr` takes `data_out` instead of `reqN_dN` (patch).
  - A CMV with `data_out_wr`=0 does not patch; the register-file value is still current.
  - `busy[dst]` is set. Set beats a same-cycle clear.
- **Issue.**
  - `en` = !empty & !hold & !flush. All issue outputs are driven combinationally from the FIFO head.
  - Class outputs are 0 when `en`=0.
  - Pop on `en`.
- **Flush.**
  - The FIFO empties at the cycle end.
  - `busy` is cleared except `busy[ex_dst]` when `ex_valid`=1; that op still completes and clears normally.
  - No push occurs in the flush cycle.
- **Simultaneous push and pop when full.** Push is refused; full is evaluated before the pop.
- **Pointers.** Wrap modulo DEPTH; a count register distinguishes full from empty.

## Timing
Reset values:
- FIFO empty, `busy`=0, `rr`=0.
- `ex_valid`=0.
- `en`=0, class outputs 0, `wb_valid`=0, `reqN_ready`=0.

Latency:
- Push in cycle p → earliest `en` in p+1 → `data_out` valid and `wb_valid`=1 in p+2.
- A dependent request is accepted at the earliest in p+2 (patched) and issued in p+3.

Other timing rules:
- `reqN_ready` is combinational from valid/state; a requester must not make `ready` a condition for asserting valid.
- Reset deassertion mid-operation: all state returns to the reset values; in-flight ops are lost.

## Structure
- Shared package: class one-hot bit positions and the `TAG_*` constants already in `defines.v`.
- Sub-module `sched_fifo`: parameterised DEPTH-entry storage with count, push/pop/flush, and full/empty outputs.
- Arbitration, scoreboard, patch logic and the execute tracker live in `arith_sched`.

## Test plan
1. **Reset.** Hold `rst`=0 with `req0_valid`=1 → `en`=0, `req0_ready`=0. Release → `req0_ready`=1 in the first cycle.
2. **Independent op.** c0: ADD r1 with d1=3, d2=4 → c1: `en`=1, `ari`=1, `data_in1`=3, `data_in2`=4 → c2: `wb_valid`=1, `wb_dst`=1.
3. **RAW.** c0: A dst r2 (result 0x0007 at c2). c1: B on `req1` with src1=r2, d1=0xdead.
   - c1: `req1_ready`=0.
   - c2: accepted.
   - c3: `data_in1`=0x0007.
4. **CMV with no write.** Same as scenario 3 with A=CMV and `data_out_wr`=0 at c2 → c3: `data_in1`=0xdead.
5. **Round-robin.** Both requesters continuously valid and independent → grants alternate 0,1,0,1 starting with `req0`.
6. **Full and flush.** `hold`=1 with 5 independent pushes:
   - 5th push: `ready`=0.
   - Assert `flush` → next cycle empty, `busy` all 0, `en`=0.
   - After `hold` drops, nothing issues.

Source files
------------

// File: rtl/arith_sched_pkg.sv
// Shared definitions for the arith issue scheduler: class one-hot bit
// positions, op tags and the operand-patch helper.
package arith_sched_pkg;

    localparam int CLS_W   = 6;
    localparam int CLS_ARI = 5;
    localparam int CLS_LGC = 4;
    localparam int CLS_SFT = 3;
    localparam int CLS_BIT = 2;
    localparam int CLS_CMV = 1;
    localparam int CLS_LEA = 0;

    localparam logic [2:0] TAG_ADD = 3'd0;
    localparam logic [2:0] TAG_SUB = 3'd1;
    localparam logic [2:0] TAG_AND = 3'd2;
    localparam logic [2:0] TAG_OR  = 3'd3;
    localparam logic [2:0] TAG_XOR = 3'd4;
    localparam logic [2:0] TAG_SHL = 3'd5;
    localparam logic [2:0] TAG_SHR = 3'd6;
    localparam logic [2:0] TAG_MOV = 3'd7;

    function automatic logic [15:0] patch_opnd(input logic used, input logic hit,
                                                input logic [15:0] rf_val,
                                                input logic [15:0] wb_val);
        return (used & hit) ? wb_val : rf_val;
    endfunction

endpackage

// File: rtl/arith_sched_fifo.sv
// In-order operation queue: DEPTH entries, wrapping pointers and an
// occupancy count that separates full from empty.
module sched_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   cnt_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push_s = push_i & ~full_o & ~flush_i;
    assign do_pop_s  = pop_i & ~empty_o & ~flush_i;
    assign rdata_o   = mem_q[rd_q];

    // Pointer and count update; flush returns the queue to empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push_s) wr_q <= wr_q + 1'b1;
            if (do_pop_s)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(do_push_s) - (PW+1)'(do_pop_s);
        end
    end

    // Entry storage; contents are only meaningful below the count
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/arith_sched.sv
// Issue scheduler for arith: round-robin intake from two requesters,
// register scoreboard for RAW/WAW, writeback operand patching, in-order issue.
module arith_sched
    import arith_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [5:0]    req0_cls,
    input  logic [2:0]    req0_tag,
    input  logic [1:0]    req0_use,
    input  logic [RW-1:0] req0_src1,
    input  logic [RW-1:0] req0_src2,
    input  logic [RW-1:0] req0_dst,
    input  logic [15:0]   req0_d1,
    input  logic [15:0]   req0_d2,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [5:0]    req1_cls,
    input  logic [2:0]    req1_tag,
    input  logic [1:0]    req1_use,
    input  logic [RW-1:0] req1_src1,
    input  logic [RW-1:0] req1_src2,
    input  logic [RW-1:0] req1_dst,
    input  logic [15:0]   req1_d1,
    input  logic [15:0]   req1_d2,
    input  logic          hold,
    input  logic          flush,
    input  logic [15:0]   data_out,
    input  logic          data_out_wr,
    output logic          en,
    output logic          ari,
    output logic          lgc,
    output logic          sft,
    output logic          bit_cls,
    output logic          cmv,
    output logic          lea,
    output logic [2:0]    tag3,
    output logic [15:0]   data_in1,
    output logic [15:0]   data_in2,
    output logic          fwd_en1,
    output logic          fwd_en2,
    output logic          wb_valid,
    output logic [RW-1:0] wb_dst
);
    localparam int NREG = 1 << RW;
    localparam int EW   = CLS_W + 3 + RW + 32;

    logic            ex_valid_q;
    logic [RW-1:0]   ex_dst_q;
    logic            rr_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clr_s;
    logic [NREG-1:0] set_s;
    logic            blk0_s, blk1_s, elig0_s, elig1_s, gnt0_s, gnt1_s, push_s;
    logic            full_s, empty_s, en_s;
    logic [15:0]     op0_1_s, op0_2_s, op1_1_s, op1_2_s;
    logic [EW-1:0]   push_data_s;
    logic [EW-1:0]   head_s;
    logic [5:0]      head_cls_s;
    logic [RW-1:0]   head_dst_s;
    logic            wb_hit_s;

    // A busy register stops blocking in the cycle its writeback clears it
    function automatic logic reg_busy(input logic [NREG-1:0] busy, input logic [RW-1:0] r,
                                      input logic clr_v, input logic [RW-1:0] clr_r);
        return busy[r] & ~(clr_v & (r == clr_r));
    endfunction

    assign blk0_s = (req0_use[0] & reg_busy(busy_q, req0_src1, ex_valid_q, ex_dst_q))
                  | (req0_use[1] & reg_busy(busy_q, req0_src2, ex_valid_q, ex_dst_q))
                  | reg_busy(busy_q, req0_dst, ex_valid_q, ex_dst_q);
    assign blk1_s = (req1_use[0] & reg_busy(busy_q, req1_src1, ex_valid_q, ex_dst_q))
                  | (req1_use[1] & reg_busy(busy_q, req1_src2, ex_valid_q, ex_dst_q))
                  | reg_busy(busy_q, req1_dst, ex_valid_q, ex_dst_q);

    assign elig0_s    = rst & req0_valid & ~blk0_s & ~full_s & ~flush;
    assign elig1_s    = rst & req1_valid & ~blk1_s & ~full_s & ~flush;
    assign gnt0_s     = elig0_s & (~elig1_s | ~rr_q);
    assign gnt1_s     = elig1_s & (~elig0_s | rr_q);
    assign push_s     = gnt0_s | gnt1_s;
    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // A CMV that does not write leaves data_out_wr low, so the RF value stands
    assign wb_hit_s = ex_valid_q & data_out_wr;
    assign op0_1_s  = patch_opnd(req0_use[0], wb_hit_s & (req0_src1 == ex_dst_q), req0_d1, data_out);
    assign op0_2_s  = patch_opnd(req0_use[1], wb_hit_s & (req0_src2 == ex_dst_q), req0_d2, data_out);
    assign op1_1_s  = patch_opnd(req1_use[0], wb_hit_s & (req1_src1 == ex_dst_q), req1_d1, data_out);
    assign op1_2_s  = patch_opnd(req1_use[1], wb_hit_s & (req1_src2 == ex_dst_q), req1_d2, data_out);

    assign push_data_s = gnt1_s ? {req1_cls, req1_tag, req1_dst, op1_1_s, op1_2_s}
                                : {req0_cls, req0_tag, req0_dst, op0_1_s, op0_2_s};

    sched_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (en_s),
        .flush_i (flush),
        .wdata_i (push_data_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign head_cls_s = head_s[EW-1 -: 6];
    assign head_dst_s = head_s[32 +: RW];
    assign en_s       = ~empty_s & ~hold & ~flush;
    assign en         = en_s;
    assign ari        = en_s & head_cls_s[CLS_ARI];
    assign lgc        = en_s & head_cls_s[CLS_LGC];
    assign sft        = en_s & head_cls_s[CLS_SFT];
    assign bit_cls    = en_s & head_cls_s[CLS_BIT];
    assign cmv        = en_s & head_cls_s[CLS_CMV];
    assign lea        = en_s & head_cls_s[CLS_LEA];
    assign tag3       = head_s[32+RW +: 3];
    assign data_in1   = head_s[31:16];
    assign data_in2   = head_s[15:0];
    assign fwd_en1    = 1'b0;
    assign fwd_en2    = 1'b0;
    assign wb_valid   = ex_valid_q;
    assign wb_dst     = ex_dst_q;

    // Scoreboard next state; on flush the only in-flight op writes back now
    always_comb begin
        clr_s  = ex_valid_q ? (NREG'(1) << ex_dst_q) : '0;
        set_s  = push_s ? (NREG'(1) << (gnt1_s ? req1_dst : req0_dst)) : '0;
        busy_d = busy_q;
        if (flush) begin
            busy_d = busy_q & clr_s & ~clr_s;
        end else begin
            busy_d = (busy_q & ~clr_s) | set_s;
        end
    end

    // Execute tracker, round-robin pointer and scoreboard
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            ex_dst_q   <= '0;
            rr_q       <= 1'b0;
            busy_q     <= '0;
        end else begin
            ex_valid_q <= en_s;
            if (en_s) ex_dst_q <= head_dst_s;
            if (elig0_s & elig1_s) rr_q <= gnt0_s;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_arith_sched.sv
// Directed bench for arith_sched: reset, issue, RAW patching, CMV no-write,
// round-robin, and full/flush behaviour against hand-computed values.
module tb_arith_sched;
    import arith_sched_pkg::*;

    localparam logic [5:0] C_ARI = 6'b100000;
    localparam logic [5:0] C_LGC = 6'b010000;
    localparam logic [5:0] C_CMV = 6'b000010;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [5:0]  req0_cls, req1_cls;
    logic [2:0]  req0_tag, req1_tag;
    logic [1:0]  req0_use, req1_use;
    logic [2:0]  req0_src1, req0_src2, req0_dst, req1_src1, req1_src2, req1_dst;
    logic [15:0] req0_d1, req0_d2, req1_d1, req1_d2;
    logic        hold, flush;
    logic [15:0] data_out;
    logic        data_out_wr;
    logic        en, ari, lgc, sft, bit_cls, cmv, lea;
    logic [2:0]  tag3;
    logic [15:0] data_in1, data_in2;
    logic        fwd_en1, fwd_en2, wb_valid;
    logic [2:0]  wb_dst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arith_sched #(.DEPTH(4), .RW(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cls(req0_cls),
        .req0_tag(req0_tag), .req0_use(req0_use), .req0_src1(req0_src1),
        .req0_src2(req0_src2), .req0_dst(req0_dst), .req0_d1(req0_d1), .req0_d2(req0_d2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cls(req1_cls),
        .req1_tag(req1_tag), .req1_use(req1_use), .req1_src1(req1_src1),
        .req1_src2(req1_src2), .req1_dst(req1_dst), .req1_d1(req1_d1), .req1_d2(req1_d2),
        .hold(hold), .flush(flush), .data_out(data_out), .data_out_wr(data_out_wr),
        .en(en), .ari(ari), .lgc(lgc), .sft(sft), .bit_cls(bit_cls), .cmv(cmv), .lea(lea),
        .tag3(tag3), .data_in1(data_in1), .data_in2(data_in2),
        .fwd_en1(fwd_en1), .fwd_en2(fwd_en2), .wb_valid(wb_valid), .wb_dst(wb_dst)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int n, input logic [5:0] cls, input logic [2:0] tag,
                           input logic [1:0] use_b, input logic [2:0] s1, input logic [2:0] s2,
                           input logic [2:0] dst, input logic [15:0] d1, input logic [15:0] d2);
        if (n == 0) begin
            req0_valid = 1'b1; req0_cls = cls; req0_tag = tag; req0_use = use_b;
            req0_src1 = s1; req0_src2 = s2; req0_dst = dst; req0_d1 = d1; req0_d2 = d2;
        end else begin
            req1_valid = 1'b1; req1_cls = cls; req1_tag = tag; req1_use = use_b;
            req1_src1 = s1; req1_src2 = s2; req1_dst = dst; req1_d1 = d1; req1_d2 = d2;
        end
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        data_out_wr = 1'b0;
    endtask

    // A writes dst_a, B reads it; B's operand is checked after acceptance
    task automatic raw_case(input string nm, input logic [5:0] cls_a, input logic [2:0] dst_a,
                            input logic [2:0] dst_b, input logic wr, input logic [15:0] exp1);
        set_req(0, cls_a, TAG_MOV, 2'b00, 3'd0, 3'd0, dst_a, 16'h1111, 16'h2222);
        #1 check_eq({nm, "_a_ready"}, 32'(req0_ready), 32'd1);
        next_cycle();
        req0_valid = 1'b0;
        set_req(1, C_LGC, TAG_AND, 2'b01, dst_a, 3'd0, dst_b, 16'hdead, 16'h00ff);
        #1 check_eq({nm, "_b_blocked"}, 32'(req1_ready), 32'd0);
        check_eq({nm, "_a_en"}, 32'(en), 32'd1);
        check_eq({nm, "_a_cls"}, 32'({ari, lgc, sft, bit_cls, cmv, lea}), 32'(cls_a));
        next_cycle();
        data_out = 16'h0007;
        data_out_wr = wr;
        #1 check_eq({nm, "_a_wb"}, 32'({wb_valid, wb_dst}), 32'({1'b1, dst_a}));
        check_eq({nm, "_b_accept"}, 32'(req1_ready), 32'd1);
        next_cycle();
        idle();
        #1 check_eq({nm, "_b_en"}, 32'({en, lgc}), 32'b11);
        check_eq({nm, "_b_data_in1"}, 32'(data_in1), 32'(exp1));
        check_eq({nm, "_b_data_in2"}, 32'(data_in2), 32'h00ff);
        next_cycle();
        next_cycle();
    endtask

    initial begin
        rst = 1'b0;
        hold = 1'b0;
        flush = 1'b0;
        data_out = 16'h0;
        data_out_wr = 1'b0;
        req1_valid = 1'b0;
        req1_cls = 6'b0; req1_tag = 3'b0; req1_use = 2'b0;
        req1_src1 = 3'd0; req1_src2 = 3'd0; req1_dst = 3'd0; req1_d1 = 16'h0; req1_d2 = 16'h0;
        set_req(0, C_ARI, TAG_ADD, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0);

        // Reset held with a valid request pending
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_en", 32'(en), 32'd0);
        check_eq("rst_ready0", 32'(req0_ready), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_fwd", 32'({fwd_en1, fwd_en2}), 32'd0);
        rst = 1'b1;
        #1 check_eq("rel_ready0", 32'(req0_ready), 32'd1);
        next_cycle();
        idle();
        #1 check_eq("rel_en", 32'({en, ari}), 32'b11);
        next_cycle();
        next_cycle();

        // Independent ADD r1 = 3 + 4
        set_req(0, C_ARI, TAG_ADD, 2'b11, 3'd6, 3'd7, 3'd1, 16'd3, 16'd4);
        #1 check_eq("ind_ready0", 32'(req0_ready), 32'd1);
        next_cycle();
        idle();
        #1 check_eq("ind_en_ari", 32'({en, ari, lgc, cmv}), 32'b1100);
        check_eq("ind_data_in1", 32'(data_in1), 32'd3);
        check_eq("ind_data_in2", 32'(data_in2), 32'd4);
        check_eq("ind_tag", 32'(tag3), 32'(TAG_ADD));
        next_cycle();
        #1 check_eq("ind_wb", 32'({wb_valid, wb_dst}), 32'({1'b1, 3'd1}));
        check_eq("ind_en_off", 32'({en, ari}), 32'b00);
        next_cycle();

        raw_case("raw", C_ARI, 3'd2, 3'd3, 1'b1, 16'h0007);
        raw_case("cmv", C_CMV, 3'd4, 3'd5, 1'b0, 16'hdead);

        // Round-robin with both requesters always eligible
        for (int k = 0; k < 4; k++) begin
            set_req(0, C_ARI, TAG_ADD, 2'b00, 3'd0, 3'd0, 3'(k), 16'h0, 16'h0);
            set_req(1, C_LGC, TAG_OR, 2'b00, 3'd0, 3'd0, 3'(4 + k), 16'h0, 16'h0);
            #1 check_eq($sformatf("rr_gnt%0d", k), 32'({req0_ready, req1_ready}),
                        (k % 2 == 0) ? 32'b10 : 32'b01);
            next_cycle();
        end
        idle();
        repeat (3) next_cycle();

        // Fill under hold, fifth push refused, then flush
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_req(0, C_ARI, TAG_SUB, 2'b00, 3'd0, 3'd0, 3'(1 + k), 16'h0, 16'h0);
            #1 check_eq($sformatf("full_ready%0d", k), 32'(req0_ready), (k < 4) ? 32'd1 : 32'd0);
            check_eq($sformatf("hold_en%0d", k), 32'(en), 32'd0);
            next_cycle();
        end
        idle();
        flush = 1'b1;
        #1 check_eq("flush_en", 32'(en), 32'd0);
        next_cycle();
        flush = 1'b0;
        hold = 1'b0;
        #1 check_eq("post_flush_en0", 32'(en), 32'd0);
        next_cycle();
        #1 check_eq("post_flush_en1", 32'(en), 32'd0);
        set_req(0, C_ARI, TAG_XOR, 2'b00, 3'd0, 3'd0, 3'd1, 16'h0, 16'h0);
        #1 check_eq("post_flush_busy_clear", 32'(req0_ready), 32'd1);
        next_cycle();
        idle();
        #1 check_eq("post_flush_issue", 32'({en, tag3}), 32'({1'b1, TAG_XOR}));
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
